// File: rtl/chimp_take2_sequence_checker.sv
// Chimp-test sequence checker: a round shows numbered targets and the
// player must click them in order. A correct full sequence passes the
// round and raises the level; any wrong click fails it and costs a strike.
// Three strikes end the game.
//
// Ports:
//   clk, iReset        clock and synchronous active-high reset
//   iStart             one-cycle pulse that begins a round
//   iLoadEn/Idx/X/Y    target-table write port, honoured only in IDLE
//   iClick             click pulse, aligned with the raw mouse coordinates
//   BoxX/BoxY          registered box coordinates, one cycle behind iClick
//   oLevel             targets in the current round (4..9)
//   oNextIdx           index of the next expected target
//   oHideNumbers       set by the first correct click of a round
//   oPass/oFail        one-cycle round-result pulses
//   oStrikes           failed rounds so far
//   oGameOver          high while in OVER
module chimp_take2_sequence_checker (
   input  logic       clk,
   input  logic       iReset,
   input  logic       iStart,
   input  logic       iLoadEn,
   input  logic [3:0] iLoadIdx,
   input  logic [2:0] iLoadX,
   input  logic [2:0] iLoadY,
   input  logic       iClick,
   input  logic [2:0] BoxX,
   input  logic [2:0] BoxY,
   output logic [3:0] oLevel,
   output logic [3:0] oNextIdx,
   output logic       oHideNumbers,
   output logic       oPass,
   output logic       oFail,
   output logic [1:0] oStrikes,
   output logic       oGameOver
);

   localparam int unsigned NUM_TARGETS = 9;
   localparam int unsigned IDX_W       = 4;
   localparam int unsigned COORD_W     = 3;
   localparam int unsigned ENTRY_W     = 2 * COORD_W;
   localparam int unsigned STRIKE_W    = 2;
   localparam int unsigned LEVEL_MIN   = 4;
   localparam int unsigned LEVEL_MAX   = 9;
   localparam int unsigned MAX_STRIKES = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 click_d;
   logic [ENTRY_W-1:0]   target_tbl [NUM_TARGETS];

   logic                 hit;
   logic                 last;
   logic [STRIKE_W-1:0]  strikes_inc;

   logic [IDX_W-1:0]     level_next;
   logic [IDX_W-1:0]     idx_next;
   logic                 hide_next;
   logic                 pass_next;
   logic                 fail_next;
   logic [STRIKE_W-1:0]  strikes_next;

   // Compare the delayed click's box against the expected target.
   assign hit         = ({BoxX, BoxY} == target_tbl[oNextIdx]);
   assign last        = (oNextIdx == oLevel - IDX_W'(1));
   assign strikes_inc = oStrikes + STRIKE_W'(1);

   // Target table: written only in IDLE, never cleared by reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && iLoadEn && iLoadIdx <= IDX_W'(NUM_TARGETS - 1))
         target_tbl[iLoadIdx] <= {iLoadX, iLoadY};
   end

   // State register and click delay.
   always_ff @(posedge clk) begin
      if (iReset) begin
         state   <= IDLE;
         click_d <= 1'b0;
      end else begin
         state   <= state_next;
         click_d <= iClick;
      end
   end

   // Next-state logic; a qualifying click wins over iStart in ARMED/PLAY.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (iStart) state_next = ARMED;
         ARMED,
         PLAY: begin
            if (click_d) begin
               if (hit)
                  state_next = last ? IDLE : PLAY;
               else
                  state_next = (strikes_inc == STRIKE_W'(MAX_STRIKES)) ? OVER : IDLE;
            end
         end
         OVER:    state_next = OVER;
         default: state_next = IDLE;
      endcase
   end

   // Output next-values; level, strikes and hide flag hold between rounds.
   always_comb begin
      level_next   = oLevel;
      idx_next     = oNextIdx;
      hide_next    = oHideNumbers;
      strikes_next = oStrikes;
      pass_next    = 1'b0;
      fail_next    = 1'b0;
      case (state)
         IDLE: begin
            if (iStart) begin
               idx_next  = '0;
               hide_next = 1'b0;
            end
         end
         ARMED,
         PLAY: begin
            if (click_d) begin
               if (hit) begin
                  if (last) begin
                     pass_next = 1'b1;
                     if (oLevel < IDX_W'(LEVEL_MAX))
                        level_next = oLevel + IDX_W'(1);
                  end else begin
                     idx_next = oNextIdx + IDX_W'(1);
                     if (state == ARMED)
                        hide_next = 1'b1;
                  end
               end else begin
                  fail_next    = 1'b1;
                  strikes_next = strikes_inc;
               end
            end
         end
         default: ;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (iReset) begin
         oLevel       <= IDX_W'(LEVEL_MIN);
         oNextIdx     <= '0;
         oHideNumbers <= 1'b0;
         oPass        <= 1'b0;
         oFail        <= 1'b0;
         oStrikes     <= '0;
         oGameOver    <= 1'b0;
      end else begin
         oLevel       <= level_next;
         oNextIdx     <= idx_next;
         oHideNumbers <= hide_next;
         oPass        <= pass_next;
         oFail        <= fail_next;
         oStrikes     <= strikes_next;
         oGameOver    <= (state_next == OVER);
      end
   end

endmodule

// File: tb/tb_chimp_take2_sequence_checker.sv
// Bench for chimp_take2_sequence_checker: directed pass/fail/game-over/
// gating/saturation/reset scenarios followed by randomized rounds, all
// checked against a round-level reference model.
module tb_chimp_take2_sequence_checker;

   logic       clk = 1'b0;
   logic       iReset = 1'b0;
   logic       iStart = 1'b0;
   logic       iLoadEn = 1'b0;
   logic [3:0] iLoadIdx = '0;
   logic [2:0] iLoadX = '0;
   logic [2:0] iLoadY = '0;
   logic       iClick = 1'b0;
   logic [2:0] BoxX = '0;
   logic [2:0] BoxY = '0;
   logic [3:0] oLevel;
   logic [3:0] oNextIdx;
   logic       oHideNumbers;
   logic       oPass;
   logic       oFail;
   logic [1:0] oStrikes;
   logic       oGameOver;

   chimp_take2_sequence_checker dut (
      .clk          (clk),
      .iReset       (iReset),
      .iStart       (iStart),
      .iLoadEn      (iLoadEn),
      .iLoadIdx     (iLoadIdx),
      .iLoadX       (iLoadX),
      .iLoadY       (iLoadY),
      .iClick       (iClick),
      .BoxX         (BoxX),
      .BoxY         (BoxY),
      .oLevel       (oLevel),
      .oNextIdx     (oNextIdx),
      .oHideNumbers (oHideNumbers),
      .oPass        (oPass),
      .oFail        (oFail),
      .oStrikes     (oStrikes),
      .oGameOver    (oGameOver)
   );

   always #5 clk = ~clk;

   // Reference model: game phase plus round bookkeeping.
   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_PLAY  = 2;
   localparam int M_OVER  = 3;

   int m_phase;
   int m_level;
   int m_idx;
   int m_hide;
   int m_strikes;
   int m_pass;
   int m_fail;
   int m_tx [9];
   int m_ty [9];

   int n_total = 0;
   int n_pass  = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"},   32'(oLevel),       32'(m_level));
      chk({tag, ".nextidx"}, 32'(oNextIdx),     32'(m_idx));
      chk({tag, ".hide"},    32'(oHideNumbers), 32'(m_hide));
      chk({tag, ".strikes"}, 32'(oStrikes),     32'(m_strikes));
      chk({tag, ".over"},    32'(oGameOver),    32'(m_phase == M_OVER));
      chk({tag, ".pass"},    32'(oPass),        32'(m_pass));
      chk({tag, ".fail"},    32'(oFail),        32'(m_fail));
   endtask

   function automatic void model_reset();
      m_phase = M_IDLE; m_level = 4; m_idx = 0; m_hide = 0;
      m_strikes = 0; m_pass = 0; m_fail = 0;
   endfunction

   function automatic void model_click(input int x, input int y, input bit st);
      m_pass = 0; m_fail = 0;
      if (m_phase == M_ARMED || m_phase == M_PLAY) begin
         if (x == m_tx[m_idx] && y == m_ty[m_idx]) begin
            if (m_idx == m_level - 1) begin
               m_pass  = 1;
               m_level = (m_level < 9) ? m_level + 1 : 9;
               m_phase = M_IDLE;
            end else begin
               m_idx++;
               m_hide  = 1;
               m_phase = M_PLAY;
            end
         end else begin
            m_fail = 1;
            m_strikes++;
            m_phase = (m_strikes == 3) ? M_OVER : M_IDLE;
         end
      end else if (m_phase == M_IDLE && st) begin
         m_phase = M_ARMED; m_idx = 0; m_hide = 0;
      end
   endfunction

   task automatic do_reset(input string tag);
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
      model_reset();
      check_all(tag);
   endtask

   task automatic do_load(input int idx, input int x, input int y);
      iLoadEn = 1'b1; iLoadIdx = 4'(idx); iLoadX = 3'(x); iLoadY = 3'(y);
      tick();
      iLoadEn = 1'b0;
      if (m_phase == M_IDLE && idx <= 8) begin
         m_tx[idx] = x; m_ty[idx] = y;
      end
      m_pass = 0; m_fail = 0;
      check_all("load");
   endtask

   task automatic do_start(input string tag);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      m_pass = 0; m_fail = 0;
      if (m_phase == M_IDLE) begin
         m_phase = M_ARMED; m_idx = 0; m_hide = 0;
      end
      check_all(tag);
   endtask

   // Click pulse, then box coordinates a cycle later; result two cycles out.
   task automatic do_click(input string tag, input int x, input int y, input bit st);
      iClick = 1'b1;
      tick();
      iClick = 1'b0; BoxX = 3'(x); BoxY = 3'(y); iStart = st;
      chk({tag, ".early_pass"}, 32'(oPass), 32'(0));
      chk({tag, ".early_fail"}, 32'(oFail), 32'(0));
      tick();
      iStart = 1'b0;
      model_click(x, y, st);
      check_all(tag);
      tick();
      m_pass = 0; m_fail = 0;
      chk({tag, ".pulse_end_pass"}, 32'(oPass), 32'(0));
      chk({tag, ".pulse_end_fail"}, 32'(oFail), 32'(0));
   endtask

   task automatic play_round(input string tag);
      do_start({tag, ".start"});
      for (int k = 0; k < 9; k++) begin
         if (m_phase != M_ARMED && m_phase != M_PLAY) break;
         do_click(tag, m_tx[m_idx], m_ty[m_idx], 1'b0);
      end
   endtask

   initial begin
      int x0, y0, x1, y1, rx, ry;

      iReset = 1'b1;
      tick();
      tick();
      iReset = 1'b0;
      model_reset();
      check_all("reset");

      // Table for all nine targets.
      do_load(0, 0, 0); do_load(1, 1, 2); do_load(2, 3, 4); do_load(3, 7, 7);
      do_load(4, 2, 3); do_load(5, 4, 1); do_load(6, 6, 5); do_load(7, 5, 0);
      do_load(8, 1, 7);

      // Pass path at level 4.
      do_start("pass.start");
      do_click("pass.c0", 0, 0, 1'b0);
      do_click("pass.c1", 1, 2, 1'b0);
      do_click("pass.c2", 3, 4, 1'b0);
      do_click("pass.c3", 7, 7, 1'b0);

      // Fail path: second click wrong, index frozen at 1.
      do_start("fail.start");
      do_click("fail.c0", 0, 0, 1'b0);
      do_click("fail.c1", 5, 5, 1'b0);

      // Gating: click in IDLE, out-of-range load, write during PLAY, iStart with click.
      do_click("gate.idle_click", 0, 0, 1'b0);
      do_load(12, 5, 5);
      do_start("gate.start");
      do_click("gate.c0", 0, 0, 1'b1);
      do_load(2, 6, 6);
      do_click("gate.c1", 1, 2, 1'b0);
      do_click("gate.c2", 3, 4, 1'b0);
      do_click("gate.c3", 7, 7, 1'b0);
      do_click("gate.c4", 2, 3, 1'b0);

      // Back-to-back clicks on consecutive cycles at level 6.
      do_start("b2b.start");
      x0 = m_tx[0]; y0 = m_ty[0]; x1 = m_tx[1]; y1 = m_ty[1];
      iClick = 1'b1;
      tick();
      BoxX = 3'(x0); BoxY = 3'(y0);
      tick();
      model_click(x0, y0, 1'b0);
      check_all("b2b.first");
      iClick = 1'b0; BoxX = 3'(x1); BoxY = 3'(y1);
      tick();
      model_click(x1, y1, 1'b0);
      check_all("b2b.second");
      for (int k = 2; k < 6; k++) do_click("b2b.rest", m_tx[k], m_ty[k], 1'b0);

      // Saturation: levels 7, 8, 9 and one more at 9.
      play_round("sat7");
      play_round("sat8");
      play_round("sat9");
      play_round("sat9b");
      chk("sat.level", 32'(oLevel), 32'(9));

      // Reset coincident with a correct delayed click: no pass, all cleared.
      do_start("rclk.start");
      do_click("rclk.c0", m_tx[0], m_ty[0], 1'b0);
      iClick = 1'b1;
      tick();
      iClick = 1'b0; BoxX = 3'(m_tx[1]); BoxY = 3'(m_ty[1]); iReset = 1'b1;
      tick();
      iReset = 1'b0;
      model_reset();
      check_all("rclk.reset");
      tick();
      check_all("rclk.after");

      // Table survives reset: full round at level 4.
      play_round("persist");

      // Game over after three failed rounds; OVER ignores start and clicks.
      for (int r = 0; r < 3; r++) begin
         do_start("over.start");
         do_click("over.bad", 5, 5, 1'b0);
      end
      chk("over.strikes", 32'(oStrikes), 32'(3));
      chk("over.flag", 32'(oGameOver), 32'(1));
      do_start("over.restart");
      do_click("over.click", m_tx[0], m_ty[0], 1'b0);
      do_load(0, 4, 4);

      // Randomized rounds.
      do_reset("rand.reset");
      for (int n = 0; n < 60; n++) begin
         if (m_phase == M_OVER) do_reset("rand.reset");
         if ($urandom_range(99) < 40)
            do_load(int'($urandom_range(15)), int'($urandom_range(7)), int'($urandom_range(7)));
         if ($urandom_range(99) < 10)
            do_click("rand.idle", int'($urandom_range(7)), int'($urandom_range(7)), 1'b0);
         do_start("rand.start");
         for (int k = 0; k < 10; k++) begin
            if (m_phase != M_ARMED && m_phase != M_PLAY) break;
            if ($urandom_range(99) < 88) begin
               rx = m_tx[m_idx]; ry = m_ty[m_idx];
            end else begin
               rx = int'($urandom_range(7)); ry = int'($urandom_range(7));
            end
            do_click("rand.click", rx, ry, 1'($urandom_range(1)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
